alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle command front end (initiator) for the combinational n-bit ALU with 4-bit ALUControl and C/Z flags.
- Accepts register-to-register commands over a valid/ready handshake.
- Reads operands from an internal register file, drives the ALU, captures ALUResult and flags, then writes the result back.
- Performs multi-bit shifts by iterating single-bit ALU shifts.
- Holds the architectural C and Z flag registers.

Parameters:
n, 4, datapath width; must match the ALU's n.
REGS, 4, register-file depth (power of 2, >=2); AW = $clog2(REGS).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
CmdValid  in  1  command present.
CmdReady  out  1  command accepted when CmdValid && CmdReady at a rising edge.
CmdOp  in  4  ALU operation code (0 AND, 1 OR, 2 ADD, 3 INC, 4 DEC, 5 NOT, 6 SUB, 7 XOR, 8 SL, 9 SR).
CmdRd, CmdRa, CmdRb  in  AW  destination and source register indices.
CmdFlagIn  in  1  carry-in / operand select / shift fill bit.
LoadValid  in  1  register-file load request.
LoadAddr  in  AW  load index.
LoadData  in  n  load value.
ALUA, ALUB  out  n  ALU operands (registered).
ALUFlagIn  out  1  ALU flag input (registered).
ALUControl  out  4  ALU op select (registered).
ALUResult  in  n  ALU result.
ALUFlagC, ALUFlagZ  in  1  ALU flag outputs.
DoneValid  out  1  one-cycle completion pulse.
DoneResult  out  n  result of the completed command.
FlagC, FlagZ  out  1  architectural flag registers.
Err  out  1  one-cycle pulse with DoneValid on an illegal opcode.

Behaviour:
- Reset (asynchronous, any state):
  - state IDLE; all register-file entries, ALU-side outputs, DoneResult, FlagC and FlagZ go to 0.
  - DoneValid and Err go to 0.
  - An in-flight command is dropped: no writeback, no Done.
- States: IDLE, EXEC, SHIFT, WRITE.
- IDLE:
  - CmdReady = !LoadValid. Load has priority; the command stalls.
  - LoadValid writes LoadData to LoadAddr at the edge. Loads are ignored outside IDLE.
  - On accept, latch op, Rd, FlagIn, A = reg[Ra], B = reg[Rb] at that edge.
  - Next state: SHIFT if op is 8 or 9, else EXEC.
  - At entry, drive ALUA=A, ALUB=B, ALUControl=op, ALUFlagIn=FlagIn.
- EXEC (1 cycle):
  - Sample ALUResult and ALUFlagZ at the end of the cycle.
  - Sample ALUFlagC only for ADD/SUB; FlagC is unchanged for all other ops.
  - Next state: WRITE.
- SHIFT:
  - k = min(B, n).
  - If k = 0: result = A, C unchanged, Z = (A==0); one cycle.
  - Otherwise k cycles. Each cycle drives ALUA = running value, ALUB = 1, ALUFlagIn = FlagIn.
  - Each cycle captures ALUResult into the running value and ALUFlagC into the pending C.
  - The final iteration's C and Z are committed.
  - Next state: WRITE.
- WRITE (1 cycle):
  - reg[Rd] <= result; FlagZ and, where applicable, FlagC update.
  - DoneValid = 1 with DoneResult = result; return to IDLE.
  - CmdReady = 0 in this cycle.
- Illegal op (10-15):
  - Goes through EXEC with ALUControl = 0.
  - WRITE asserts DoneValid and Err.
  - No register write, flags unchanged, DoneResult = 0.
- Latency, with accept at edge T:
  - Non-shift ops: DoneValid high during cycle T+2.
  - Shifts: DoneValid high during cycle T+max(k,1)+1.
  - Next accept possible at the edge ending the WRITE cycle + 1 (one IDLE cycle minimum).
- ALU-side outputs hold their last value outside EXEC/SHIFT.
- Rd equal to Ra or Rb is legal: operands were latched at accept.
- Arithmetic width is n; wrap-around comes from the ALU (e.g. INC of all-ones gives 0, Z=1).

Test Plan:
1. Reset; load R0=4'h9, R1=4'h8; ADD Rd=2 Ra=0 Rb=1 FlagIn=0 accepted at T -> DoneValid at T+2, DoneResult=4'h1, FlagC=1, FlagZ=0, R2=4'h1.
2. After test 1, AND Rd=3 Ra=0 Rb=1 -> DoneResult=4'h8, FlagZ=0, FlagC stays 1; then SUB Rd=3 Ra=0 Rb=0 FlagIn=0 -> DoneResult=0, FlagZ=1, FlagC=0.
3. Load R0=4'b1011, R1=4'd3; SL Rd=2 Ra=0 Rb=1 FlagIn=0 -> three SHIFT cycles, ALUB=1 each, DoneValid at T+4, DoneResult=4'b1000, FlagC=1. Repeat with R1=0 -> DoneResult=4'b1011 at T+2, FlagC unchanged.
4. CmdOp=4'hC with FlagC=1, FlagZ=0 -> DoneValid=1 and Err=1 at T+2, no register changed, flags unchanged.
5. LoadValid and CmdValid both high in IDLE -> CmdReady=0, load written that edge; command accepted next cycle and reads the new value.
6. Assert rst during the second SHIFT cycle of a k=3 SR -> immediately CmdReady=1, all outputs 0, no DoneValid afterwards, Rd not written.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle command sequencer in front of a combinational n-bit ALU.
// Holds the register file and the architectural C/Z flags, and turns multi-bit shifts into repeated single-bit shifts.
module alu_sequencer #(
  parameter int n    = 4,
  parameter int REGS = 4,
  localparam int AW  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CmdValid,
  output logic          CmdReady,
  input  logic [3:0]    CmdOp,
  input  logic [AW-1:0] CmdRd,
  input  logic [AW-1:0] CmdRa,
  input  logic [AW-1:0] CmdRb,
  input  logic          CmdFlagIn,
  input  logic          LoadValid,
  input  logic [AW-1:0] LoadAddr,
  input  logic [n-1:0]  LoadData,
  output logic [n-1:0]  ALUA,
  output logic [n-1:0]  ALUB,
  output logic          ALUFlagIn,
  output logic [3:0]    ALUControl,
  input  logic [n-1:0]  ALUResult,
  input  logic          ALUFlagC,
  input  logic          ALUFlagZ,
  output logic          DoneValid,
  output logic [n-1:0]  DoneResult,
  output logic          FlagC,
  output logic          FlagZ,
  output logic          Err
);

  localparam int CW = $clog2(n + 1);
  localparam logic [n:0] N_VAL = (n + 1)'(n);

  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SL  = 4'd8;
  localparam logic [3:0] OP_SR  = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_WRITE} state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    regs_q [REGS];
  logic [n-1:0]    regs_d [REGS];
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            c_valid_q, c_valid_d;
  logic            pend_c_q, pend_c_d;
  logic            pend_z_q, pend_z_d;
  logic [n-1:0]    alu_a_q, alu_a_d;
  logic [n-1:0]    alu_b_q, alu_b_d;
  logic            alu_flag_in_q, alu_flag_in_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [n-1:0]    done_result_q, done_result_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;

  logic            cmd_accept;
  logic            op_shift;
  logic            op_illegal;
  logic [n-1:0]    opnd_a;
  logic [n-1:0]    opnd_b;
  logic [CW-1:0]   shift_k;

  assign cmd_accept = CmdValid && CmdReady;
  assign op_shift   = (CmdOp == OP_SL) || (CmdOp == OP_SR);
  assign op_illegal = CmdOp > OP_SR;
  assign opnd_a     = regs_q[CmdRa];
  assign opnd_b     = regs_q[CmdRb];
  assign shift_k    = ({1'b0, opnd_b} >= N_VAL) ? CW'(n) : CW'(opnd_b);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_accept) state_d = op_shift ? S_SHIFT : S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_SHIFT: if (cnt_q <= CW'(1)) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    CmdReady  = (state_q == S_IDLE) && !LoadValid;
    DoneValid = (state_q == S_WRITE);
    Err       = (state_q == S_WRITE) && err_q;
  end

  // Datapath next-value logic
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the updated value.
    regs_d        = regs_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    c_valid_d     = c_valid_q;
    pend_c_d      = pend_c_q;
    pend_z_d      = pend_z_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_flag_in_d = alu_flag_in_q;
    alu_ctrl_d    = alu_ctrl_q;
    done_result_d = done_result_q;
    flag_c_d      = flag_c_q;
    flag_z_d      = flag_z_q;

    unique case (state_q)
      S_IDLE: begin
        if (LoadValid) begin
          regs_d[LoadAddr] = LoadData;
        end else if (CmdValid) begin
          rd_d          = CmdRd;
          err_d         = op_illegal;
          alu_ctrl_d    = op_illegal ? 4'd0 : CmdOp;
          alu_a_d       = opnd_a;
          alu_b_d       = op_shift ? n'(1) : opnd_b;
          alu_flag_in_d = CmdFlagIn;
          cnt_d         = shift_k;
          // Only arithmetic ops and non-empty shifts produce a carry worth committing.
          c_valid_d     = op_shift ? (shift_k != '0)
                                   : ((CmdOp == OP_ADD) || (CmdOp == OP_SUB));
        end
      end
      S_EXEC: begin
        done_result_d = err_q ? '0 : ALUResult;
        pend_c_d      = ALUFlagC;
        pend_z_d      = ALUFlagZ;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          done_result_d = alu_a_q;
          pend_z_d      = (alu_a_q == '0);
        end else begin
          pend_c_d = ALUFlagC;
          pend_z_d = ALUFlagZ;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) done_result_d = ALUResult;
          else                 alu_a_d       = ALUResult;
        end
      end
      S_WRITE: begin
        if (!err_q) begin
          regs_d[rd_q] = done_result_q;
          flag_z_d     = pend_z_q;
          if (c_valid_q) flag_c_d = pend_c_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is reset entry by entry because its contents are architecturally visible after reset.
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      c_valid_q     <= 1'b0;
      pend_c_q      <= 1'b0;
      pend_z_q      <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_flag_in_q <= 1'b0;
      alu_ctrl_q    <= '0;
      done_result_q <= '0;
      flag_c_q      <= 1'b0;
      flag_z_q      <= 1'b0;
    end else begin
      // NOTE: flops use non-blocking '<=' so every register samples the pre-edge values.
      regs_q        <= regs_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      c_valid_q     <= c_valid_d;
      pend_c_q      <= pend_c_d;
      pend_z_q      <= pend_z_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_flag_in_q <= alu_flag_in_d;
      alu_ctrl_q    <= alu_ctrl_d;
      done_result_q <= done_result_d;
      flag_c_q      <= flag_c_d;
      flag_z_q      <= flag_z_d;
    end
  end

  assign ALUA       = alu_a_q;
  assign ALUB       = alu_b_q;
  assign ALUFlagIn  = alu_flag_in_q;
  assign ALUControl = alu_ctrl_q;
  assign DoneResult = done_result_q;
  assign FlagC      = flag_c_q;
  assign FlagZ      = flag_z_q;

endmodule
